// File: rtl/ode_ram_pkg.sv
// Shared constants and types for the solver RAM port arbiters.
package ode_ram_pkg;

    // Default requester population of one RAM port
    localparam int ARB_NUM_REQ  = 3;
    localparam int ARB_ID_WIDTH = 2;

    // Requester indices
    localparam int REQ_LOADER = 0;
    localparam int REQ_SOLVER = 1;
    localparam int REQ_WRITER = 2;

    // Solver RAM port geometry
    localparam int RAM_ADDR_WIDTH_P0 = 10;
    localparam int RAM_ADDR_WIDTH_P1 = 12;
    localparam int RAM_ADDR_WIDTH_P2 = 12;
    localparam int RAM_ADDR_WIDTH_P3 = 7;
    localparam int RAM_DATA_WIDTH    = 64;

    // Arbiter grant state: open for round-robin or held by the current owner
    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side and RAM-side signals of one arbitrated RAM port.
interface ram_port_arbiter_if
    import ode_ram_pkg::*;
#(
    parameter int DATA_WIDTH    = RAM_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = RAM_ADDR_WIDTH_P1,
    parameter int NUM_REQ       = ARB_NUM_REQ
);
    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ-1:0]               req_write;
    logic [NUM_REQ-1:0]               req_lock;
    logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_address;
    logic [NUM_REQ*DATA_WIDTH-1:0]    req_data;
    logic [NUM_REQ-1:0]               req_ready;
    logic [NUM_REQ-1:0]               rsp_valid;
    logic [DATA_WIDTH-1:0]            rsp_data;
    logic [ADDRESS_WIDTH-1:0]         ram_address;
    logic [DATA_WIDTH-1:0]            ram_data_write;
    logic                             ram_WR_signal;
    logic [DATA_WIDTH-1:0]            ram_data_read;

    // Arbiter side
    modport slave (
        input  req_valid, req_write, req_lock, req_address, req_data, ram_data_read,
        output req_ready, rsp_valid, rsp_data, ram_address, ram_data_write, ram_WR_signal
    );

    // Requesters plus RAM side
    modport master (
        output req_valid, req_write, req_lock, req_address, req_data, ram_data_read,
        input  req_ready, rsp_valid, rsp_data, ram_address, ram_data_write, ram_WR_signal
    );

endinterface

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first requester after last_grant (wrapping) wins.
module rr_priority_picker #(
    parameter int NUM_REQ  = 3,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] last_grant,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_id,
    output logic                any
);

    // Walk distances 1..NUM_REQ from last_grant; the nearest active request wins
    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!any && req[i] && (i == (int'(last_grant) + k) % NUM_REQ)) begin
                    any      = 1'b1;
                    grant[i] = 1'b1;
                    grant_id = ID_WIDTH'(i);
                end
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one solver RAM port among NUM_REQ requesters: round-robin grant
// with optional lock, registered RAM command, read tags routed back after
// the RAM's registered read.
module ram_port_arbiter
    import ode_ram_pkg::*;
#(
    parameter int DATA_WIDTH    = RAM_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = RAM_ADDR_WIDTH_P1,
    parameter int NUM_REQ       = ARB_NUM_REQ,
    parameter int ID_WIDTH      = ARB_ID_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    ram_port_arbiter_if.slave  bus
);

    // Command register stage plus the RAM's own read register
    localparam int TAG_STAGES = 2;

    arb_state_e                  state_q, state_d;
    logic [ID_WIDTH-1:0]         owner_q, last_q, acc_id;
    logic [NUM_REQ-1:0]          owner_oh, pick_gnt, grant;
    logic [ID_WIDTH-1:0]         pick_id;
    logic                        pick_any, accept;
    logic                        sel_write, sel_lock;
    logic [ADDRESS_WIDTH-1:0]    sel_addr, addr_q;
    logic [DATA_WIDTH-1:0]       sel_data, wdata_q;
    logic                        wr_q;
    logic                        vld_in;
    logic [TAG_STAGES:1]                 vld_pipe;
    logic [TAG_STAGES:1][ID_WIDTH-1:0]   id_pipe;

    rr_priority_picker #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .req        (bus.req_valid),
        .last_grant (last_q),
        .grant      (pick_gnt),
        .grant_id   (pick_id),
        .any        (pick_any)
    );

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign owner_oh[i]      = (owner_q == ID_WIDTH'(i));
        assign bus.rsp_valid[i] = vld_pipe[TAG_STAGES] && (id_pipe[TAG_STAGES] == ID_WIDTH'(i));
    end

    // Grant selection and lock next-state; reset forces all readies low
    always_comb begin
        state_d = state_q;
        grant   = '0;
        acc_id  = pick_id;
        accept  = 1'b0;
        case (state_q)
            ARB_OPEN: begin
                grant  = pick_gnt;
                acc_id = pick_id;
                accept = pick_any;
            end
            ARB_LOCKED: begin
                // owner keeps the port even while it idles
                grant  = owner_oh & bus.req_valid;
                acc_id = owner_q;
                accept = |(owner_oh & bus.req_valid);
            end
        endcase
        if (!rst_n) begin
            grant  = '0;
            accept = 1'b0;
        end
        if (accept) state_d = sel_lock ? ARB_LOCKED : ARB_OPEN;
    end

    // One-hot mux of the granted requester's beat
    always_comb begin
        sel_write = 1'b0;
        sel_lock  = 1'b0;
        sel_addr  = '0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_write = bus.req_write[i];
                sel_lock  = bus.req_lock[i];
                sel_addr  = bus.req_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                sel_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Lock state, owner and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_OPEN;
            owner_q <= '0;
            last_q  <= ID_WIDTH'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q <= acc_id;
                last_q  <= acc_id;
            end
        end
    end

    // RAM command register; write strobe is a single-cycle pulse per write beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
        end else if (accept) begin
            addr_q  <= sel_addr;
            wdata_q <= sel_data;
            wr_q    <= sel_write;
        end else begin
            wr_q    <= 1'b0;
        end
    end

    assign vld_in = accept & ~sel_write;

    // Read tag pipe tracking each read through command reg and RAM read reg
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[TAG_STAGES-1:1], vld_in};
            id_pipe  <= {id_pipe[TAG_STAGES-1:1], acc_id};
        end
    end

    assign bus.req_ready      = grant;
    assign bus.rsp_data       = bus.ram_data_read;
    assign bus.ram_address    = addr_q;
    assign bus.ram_data_write = wdata_q;
    assign bus.ram_WR_signal  = wr_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, a transaction-level model
// checked every cycle, and directed scenarios with literal expectations.
module tb_ram_port_arbiter;

    localparam int DW = 64;
    localparam int AW = 12;
    localparam int NR = 3;
    localparam int IW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_REQ(NR)) bus();

    ram_port_arbiter #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .NUM_REQ       (NR),
        .ID_WIDTH      (IW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errs   = 0;
    int checks = 0;

    function automatic logic [DW-1:0] init_word(int a);
        return 64'hA5A5_0000_0000_0000 | 64'(a);
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // RAM: one write port, registered read returning the pre-write contents
    logic [DW-1:0] mem [4096];
    initial begin
        logic [DW-1:0] rd;
        for (int a = 0; a < 4096; a++) mem[a] = init_word(a);
        bus.ram_data_read = '0;
        forever begin
            @(posedge clk);
            rd = mem[bus.ram_address];
            if (bus.ram_WR_signal) mem[bus.ram_address] = bus.ram_data_write;
            bus.ram_data_read <= rd;
        end
    end

    // ---------------- transaction-level model ----------------
    int            cyc_n    = 0;
    int            m_last   = NR - 1;
    int            m_owner  = 0;
    bit            m_locked = 1'b0;
    logic [AW-1:0] m_addr   = '0;
    logic [DW-1:0] m_wdata  = '0;
    bit            m_wr     = 1'b0;
    bit            pend_wr  = 1'b0;
    int            pend_a   = 0;
    logic [DW-1:0] pend_d   = '0;
    logic [DW-1:0] shadow  [int];
    int            rsp_id  [int];
    logic [DW-1:0] rsp_dat [int];

    function automatic logic [DW-1:0] model_read(int a);
        return shadow.exists(a) ? shadow[a] : init_word(a);
    endfunction

    function automatic bit has(logic [NR-1:0] v, int i);
        return ((v >> i) & NR'(1)) != 0;
    endfunction

    // Which requester the rules say gets the port this cycle
    function automatic logic [NR-1:0] model_ready();
        if (!rst_n) return '0;
        if (m_locked) return has(bus.req_valid, m_owner) ? (NR'(1) << m_owner) : '0;
        for (int k = 1; k <= NR; k++) begin
            int i = (m_last + k) % NR;
            if (has(bus.req_valid, i)) return NR'(1) << i;
        end
        return '0;
    endfunction

    task automatic model_step();
        logic [NR-1:0] er, ev;
        logic [DW-1:0] ed;
        int acc, a;
        if (!rst_n) begin
            m_last = NR - 1; m_owner = 0; m_locked = 1'b0;
            m_addr = '0; m_wdata = '0; m_wr = 1'b0; pend_wr = 1'b0;
            rsp_id.delete(); rsp_dat.delete();
        end else if (pend_wr) begin
            // write driven this cycle lands in the RAM at the coming edge
            shadow[pend_a] = pend_d;
            pend_wr = 1'b0;
        end
        er = model_ready();
        ev = '0;
        ed = '0;
        if (rsp_id.exists(cyc_n)) begin
            ev = NR'(1) << rsp_id[cyc_n];
            ed = rsp_dat[cyc_n];
        end
        chk("ready",     64'(bus.req_ready),      64'(er));
        chk("rsp_valid", 64'(bus.rsp_valid),      64'(ev));
        if (ev != 0) chk("rsp_data", bus.rsp_data, ed);
        chk("ram_wr",    64'(bus.ram_WR_signal),  64'(m_wr));
        chk("ram_addr",  64'(bus.ram_address),    64'(m_addr));
        chk("ram_wdata", bus.ram_data_write,      m_wdata);
        if (rst_n) begin
            acc = -1;
            for (int i = 0; i < NR; i++) if (has(er, i)) acc = i;
            if (acc >= 0) begin
                a        = int'(bus.req_address[acc*AW +: AW]);
                m_last   = acc;
                m_owner  = acc;
                m_locked = has(bus.req_lock, acc);
                m_addr   = AW'(a);
                m_wdata  = bus.req_data[acc*DW +: DW];
                m_wr     = has(bus.req_write, acc);
                if (m_wr) begin
                    pend_wr = 1'b1;
                    pend_a  = a;
                    pend_d  = m_wdata;
                end else begin
                    rsp_id[cyc_n + 2]  = acc;
                    rsp_dat[cyc_n + 2] = model_read(a);
                end
            end else begin
                m_wr = 1'b0;
            end
        end
        if (rsp_id.exists(cyc_n)) begin
            rsp_id.delete(cyc_n);
            rsp_dat.delete(cyc_n);
        end
        cyc_n++;
    endtask

    initial forever begin
        @(negedge clk);
        model_step();
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic drive(int i, bit v, bit w, bit l, int a, logic [DW-1:0] d);
        bus.req_valid[i]              = v;
        bus.req_write[i]              = w;
        bus.req_lock[i]               = l;
        bus.req_address[i*AW +: AW]   = AW'(a);
        bus.req_data[i*DW +: DW]      = d;
    endtask

    initial begin
        int pulses;
        bus.req_valid   = '0;
        bus.req_write   = '0;
        bus.req_lock    = '0;
        bus.req_address = '0;
        bus.req_data    = '0;

        // Reset held with all requesters asking: nothing may be granted
        drive(0, 1, 0, 0, 5, '0);
        drive(1, 1, 0, 0, 6, '0);
        drive(2, 1, 0, 0, 7, '0);
        repeat (2) begin
            neg();
            chk("rst_ready", 64'(bus.req_ready), 64'b000);
        end
        chk("rst_rsp",  64'(bus.rsp_valid),     64'b000);
        chk("rst_wr",   64'(bus.ram_WR_signal), 64'b0);
        chk("rst_addr", 64'(bus.ram_address),   64'd0);
        cyc();
        rst_n = 1'b1;

        // Three reads: grants 0,1,2 back to back, responses 2 cycles later
        neg(); chk("t1_g0", 64'(bus.req_ready), 64'b001);
        cyc(); drive(0, 0, 0, 0, 0, '0);
        neg(); chk("t1_g1", 64'(bus.req_ready), 64'b010);
        cyc(); drive(1, 0, 0, 0, 0, '0);
        neg(); chk("t1_g2", 64'(bus.req_ready), 64'b100);
        chk("t1_rv0", 64'(bus.rsp_valid), 64'b001);
        chk("t1_rd0", bus.rsp_data, 64'hA5A5_0000_0000_0005);
        cyc(); drive(2, 0, 0, 0, 0, '0);
        neg(); chk("t1_rv1", 64'(bus.rsp_valid), 64'b010);
        chk("t1_rd1", bus.rsp_data, 64'hA5A5_0000_0000_0006);
        cyc();
        neg(); chk("t1_rv2", 64'(bus.rsp_valid), 64'b100);
        chk("t1_rd2", bus.rsp_data, 64'hA5A5_0000_0000_0007);

        // Write by 1 then immediate read by 2 of the same address
        cyc(); drive(1, 1, 1, 0, 100, 64'hDEAD);
        neg(); chk("t2_gw", 64'(bus.req_ready), 64'b010);
        cyc(); drive(1, 0, 0, 0, 0, '0); drive(2, 1, 0, 0, 100, '0);
        neg(); chk("t2_gr", 64'(bus.req_ready), 64'b100);
        chk("t2_wr",   64'(bus.ram_WR_signal), 64'b1);
        chk("t2_addr", 64'(bus.ram_address),   64'd100);
        chk("t2_wd",   bus.ram_data_write,     64'hDEAD);
        cyc(); drive(2, 0, 0, 0, 0, '0);
        neg();
        cyc();
        neg(); chk("t2_rv", 64'(bus.rsp_valid), 64'b100);
        chk("t2_rd", bus.rsp_data, 64'hDEAD);

        // Locked stream of 4 reads by 0 while 1 and 2 wait
        cyc();
        drive(1, 1, 0, 0, 30, '0);
        drive(2, 1, 0, 0, 40, '0);
        for (int b = 0; b < 4; b++) begin
            drive(0, 1, 0, (b < 3), 20 + b, '0);
            neg(); chk("t3_lock", 64'(bus.req_ready), 64'b001);
            cyc();
        end
        drive(0, 0, 0, 0, 0, '0);
        neg(); chk("t3_next", 64'(bus.req_ready), 64'b010);
        cyc(); drive(1, 0, 0, 0, 0, '0);
        neg(); chk("t3_then", 64'(bus.req_ready), 64'b100);
        cyc(); drive(2, 0, 0, 0, 0, '0);
        repeat (3) begin neg(); cyc(); end

        // Owner 1 locks, then idles 3 cycles while 0 and 2 wait
        drive(1, 1, 0, 1, 200, '0);
        neg(); chk("t4_lockbeat", 64'(bus.req_ready), 64'b010);
        cyc();
        drive(1, 0, 0, 0, 0, '0);
        drive(0, 1, 0, 0, 10, '0);
        drive(2, 1, 0, 0, 11, '0);
        repeat (3) begin
            neg();
            chk("t4_hold_ready", 64'(bus.req_ready),     64'b000);
            chk("t4_hold_wr",    64'(bus.ram_WR_signal), 64'b0);
            cyc();
        end
        drive(1, 1, 1, 0, 201, 64'h2222);
        neg(); chk("t4_unlock", 64'(bus.req_ready), 64'b010);
        cyc(); drive(1, 0, 0, 0, 0, '0);
        neg(); chk("t4_release", 64'(bus.req_ready), 64'b100);
        cyc(); drive(2, 0, 0, 0, 0, '0);
        neg(); chk("t4_rr", 64'(bus.req_ready), 64'b001);
        cyc(); drive(0, 0, 0, 0, 0, '0);
        repeat (3) begin neg(); cyc(); end

        // Reset right after a read is accepted: response dropped
        drive(2, 1, 0, 0, 5, '0);
        neg(); chk("t5_gr", 64'(bus.req_ready), 64'b100);
        cyc();
        drive(2, 0, 0, 0, 0, '0);
        drive(0, 1, 1, 0, 300, 64'hBEEF);
        drive(1, 1, 0, 0, 8, '0);
        rst_n = 1'b0;
        #1;
        chk("t5_ready", 64'(bus.req_ready),     64'b000);
        chk("t5_addr",  64'(bus.ram_address),   64'd0);
        chk("t5_wr",    64'(bus.ram_WR_signal), 64'b0);
        chk("t5_wd",    bus.ram_data_write,     64'd0);
        chk("t5_rv",    64'(bus.rsp_valid),     64'b000);
        repeat (2) begin
            neg(); chk("t5_norsp", 64'(bus.rsp_valid), 64'b000);
            cyc();
        end
        rst_n = 1'b1;
        // requester 0 wins first after reset; its write is then cancelled by reset
        neg(); chk("t5_first", 64'(bus.req_ready), 64'b001);
        cyc();
        drive(0, 0, 0, 0, 0, '0);
        drive(1, 0, 0, 0, 0, '0);
        rst_n = 1'b0;
        #1;
        chk("t5_wr_cancel", 64'(bus.ram_WR_signal), 64'b0);
        neg(); cyc();
        rst_n = 1'b1;
        drive(0, 1, 0, 0, 300, '0);
        neg(); chk("t5_rd_gr", 64'(bus.req_ready), 64'b001);
        cyc(); drive(0, 0, 0, 0, 0, '0);
        neg(); cyc();
        neg(); chk("t5_old_rv", 64'(bus.rsp_valid), 64'b001);
        chk("t5_old_data", bus.rsp_data, 64'hA5A5_0000_0000_012C);
        cyc();

        // Single requester streaming 10 reads at full rate
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            if (k < 10) drive(2, 1, 0, 0, 50 + k, '0);
            else        drive(2, 0, 0, 0, 0, '0);
            neg();
            if (k < 10) chk("t6_ready", 64'(bus.req_ready), 64'b100);
            if (k >= 2) begin
                chk("t6_rv", 64'(bus.rsp_valid), 64'b100);
                chk("t6_rd", bus.rsp_data, init_word(50 + k - 2));
            end
            if (bus.rsp_valid[2]) pulses++;
            cyc();
        end
        neg(); chk("t6_tail", 64'(bus.rsp_valid), 64'b000);
        chk("t6_pulses", 64'(pulses), 64'd10);
        cyc();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
